// File: rtl/wino_f_m3_stream.sv
// wino_f_m3_stream: streaming 3-tap tile correlator for the Winograd F(M,3) path.
// Each tile of M+2 signed samples yields M signed results through a 4-stage
// pipeline (input, products, sums, reduction) feeding a held output register.
// Ports:
//   clk, rst (async, active-low)
//   coef_we/coef_sel/coef_data : coefficient load, sel 3 ignored
//   in_valid/in_ready/D        : tile input, d[0] in MSB field
//   out_valid/out_ready/Z      : results, z[0] in MSB field
//   busy                       : any stage or the output holds a tile
module wino_f_m3_stream #(
  parameter int W   = 10,
  parameter int CW  = 10,
  parameter int M   = 7,
  parameter int OW  = 10,
  parameter int SAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coef_we,
  input  logic [1:0]         coef_sel,
  input  logic [CW-1:0]      coef_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [(M+2)*W-1:0] D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [M*OW-1:0]    Z,
  output logic               busy
);

  localparam int N  = M + 2;
  localparam int PW = W + CW;
  localparam int SW = W + CW + 2;
  localparam int XW = (OW > SW) ? OW : SW;
  localparam bit SATB = (SAT != 0);

  // live coefficients
  logic signed [CW-1:0] r_g [3];

  // stage 1: tile and coefficient snapshot
  logic                 r_v1;
  logic [N*W-1:0]       r_d1;
  logic signed [CW-1:0] r_g1 [3];

  // stage 2: products
  logic                 r_v2;
  logic signed [PW-1:0] r_p2 [M][3];

  // stage 3: exact sums
  logic                 r_v3;
  logic signed [SW-1:0] r_s3 [M];

  // stage 4: reduced results
  logic                 r_v4;
  logic [M*OW-1:0]      r_r4;

  // output register
  logic                 r_ov;
  logic [M*OW-1:0]      r_z;

  logic                 w_stall;
  logic                 w_adv;
  logic signed [W-1:0]  w_d1 [N];
  logic signed [PW-1:0] w_p [M][3];
  logic signed [SW-1:0] w_s [M];
  logic [M*OW-1:0]      w_red;

  // a full output that is not taken freezes the whole pipe
  assign w_stall   = r_ov & ~out_ready;
  assign w_adv     = ~w_stall;
  assign in_ready  = w_adv;
  assign out_valid = r_ov;
  assign Z         = r_z;
  assign busy      = r_v1 | r_v2 | r_v3 | r_v4 | r_ov;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++)
        r_g[k] <= '0;
    end else if (coef_we) begin
      case (coef_sel)
        2'd0:    r_g[0] <= coef_data;
        2'd1:    r_g[1] <= coef_data;
        2'd2:    r_g[2] <= coef_data;
        default: ;
      endcase
    end
  end

  // the snapshot takes r_g before any same-edge write lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
      for (int k = 0; k < 3; k++)
        r_g1[k] <= '0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_d1 <= D;
        r_g1 <= r_g;
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_unpack
    assign w_d1[j] = $signed(r_d1[(N-1-j)*W +: W]);
  end

  for (genvar i = 0; i < M; i++) begin : g_mul
    for (genvar k = 0; k < 3; k++) begin : g_tap
      assign w_p[i][k] = PW'(w_d1[i+k]) * PW'(r_g1[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2 <= 1'b0;
      for (int i = 0; i < M; i++)
        for (int k = 0; k < 3; k++)
          r_p2[i][k] <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) r_p2 <= w_p;
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_sum
    assign w_s[i] = SW'(r_p2[i][0])
                  + SW'(r_p2[i][1])
                  + SW'(r_p2[i][2]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v3 <= 1'b0;
      for (int i = 0; i < M; i++)
        r_s3[i] <= '0;
    end else if (w_adv) begin
      r_v3 <= r_v2;
      if (r_v2) r_s3 <= w_s;
    end
  end

  // overflow: bits above the OW-1 sign position disagree with it
  for (genvar i = 0; i < M; i++) begin : g_red
    logic signed [XW-1:0] w_x;
    logic                 w_ovf;
    logic [OW-1:0]        w_sat;
    assign w_x   = XW'(r_s3[i]);
    assign w_ovf = ~((&w_x[XW-1:OW-1]) | ~(|w_x[XW-1:OW-1]));
    assign w_sat = {w_x[XW-1], {(OW-1){~w_x[XW-1]}}};
    assign w_red[(M-1-i)*OW +: OW] =
      (SATB && w_ovf) ? w_sat : w_x[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v4 <= 1'b0;
      r_r4 <= '0;
    end else if (w_adv) begin
      r_v4 <= r_v3;
      if (r_v3) r_r4 <= w_red;
    end
  end

  // Z only reloads on a new result, so it keeps the last value otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ov <= 1'b0;
      r_z  <= '0;
    end else if (w_adv) begin
      r_ov <= r_v4;
      if (r_v4) r_z <= r_r4;
    end
  end

endmodule
